// File: rtl/dmem_ctrl_if.sv
// ============================================================================
// Module   : dmem_ctrl_if
// Purpose  : CPU-side request/response bundle for the data-memory controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              misalign;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  busy, done, rdata, misalign
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output busy, done, rdata, misalign
    );
endinterface

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Synchronous word-array data memory with req/done handshake,
//            byte/half/word access and RD_LAT read wait states.
//            Optional: DMEM_MISALIGN_EXC_EN suppresses misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    dmem_ctrl_if.slave   bus
);
    localparam int         c_IDX_W    = $clog2(DEPTH);
    localparam logic [1:0] c_CNT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_misalign;
    logic [31:0]         r_rdata;
    logic [c_IDX_W-1:0]  r_idx;
    logic [1:0]          r_off;
    logic [1:0]          r_size;
    logic                r_sext;
    logic [31:0]         r_mem [DEPTH];

    logic [c_IDX_W-1:0]  w_idx;
    logic [1:0]          w_off;
    logic                w_is_word;
    logic                w_is_half;
    logic                w_misalign;
    logic                w_accept;
    logic                w_commit;
    logic [3:0]          w_be;
    logic [31:0]         w_wlane;

    // Right-align the selected lane(s); size 11 behaves as a word.
    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [1:0]  sz,
                                            input logic [1:0]  off,
                                            input logic        sext);
        logic [15:0] h;
        logic [7:0]  b;
        h = off[1] ? word[31:16] : word[15:0];
        b = word[8*off +: 8];
        if (sz[1])
            return word;
        else if (sz[0])
            return {{16{sext & h[15]}}, h};
        else
            return {{24{sext & b[7]}}, b};
    endfunction

    always_comb begin
        w_idx     = bus.addr[c_IDX_W+1:2];
        w_off     = bus.addr[1:0];
        w_is_word = bus.size[1];
        w_is_half = (bus.size == 2'b01);
`ifdef DMEM_MISALIGN_EXC_EN
        w_misalign = (w_is_half && w_off[0]) || (w_is_word && (w_off != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        w_accept = (r_state == S_IDLE) && bus.req;
        w_commit = rst_n && w_accept && bus.we && !w_misalign;
        if (w_is_word) begin
            w_be    = 4'hF;
            w_wlane = bus.wdata;
        end else if (w_is_half) begin
            w_be    = w_off[1] ? 4'hC : 4'h3;
            w_wlane = {2{bus.wdata[15:0]}};
        end else begin
            w_be    = 4'b0001 << w_off;
            w_wlane = {4{bus.wdata[7:0]}};
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_rdata    <= 32'd0;
            r_idx      <= '0;
            r_off      <= 2'd0;
            r_size     <= 2'd0;
            r_sext     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done     <= 1'b0;
                    r_misalign <= 1'b0;
                    if (bus.req) begin
                        r_idx  <= w_idx;
                        r_off  <= w_off;
                        r_size <= bus.size;
                        r_sext <= bus.sign_ext;
                        r_busy <= 1'b1;
                        if (w_misalign) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_misalign <= 1'b1;
                        end else if (bus.we) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (RD_LAT == 0) begin
                            r_rdata <= extract(r_mem[w_idx], bus.size, w_off, bus.sign_ext);
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt   <= c_CNT_INIT;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_rdata <= extract(r_mem[r_idx], r_size, r_off, r_sext);
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_misalign <= 1'b0;
                end
            endcase
        end
    end

    // Address bits above the word index wrap and are intentionally ignored.
    generate
        if (ADDR_W > c_IDX_W + 2) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^bus.addr[ADDR_W-1:c_IDX_W+2];
        end
    endgenerate

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rdata    = r_rdata;
    assign bus.misalign = r_misalign;

endmodule

`default_nettype wire
